// File: rtl/vga_pkg.sv
// Shared VGA timing constants. The defaults give 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_CNT_W    = 10;
    localparam bit VGA_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel generator and sync pins.
interface vga_timing_gen_if #(
    parameter int CNT_W = vga_pkg::VGA_CNT_W
);
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    modport master (output hsync, vsync, video_on, x, y, line_start, frame_start);
    modport slave  (input  hsync, vsync, video_on, x, y, line_start, frame_start);
endinterface

// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable and synchronous clear to N-1.
// nxt is the value the counter takes at the coming edge; wrap flags an enabled N-1 -> 0 step.
module mod_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] nxt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;
    logic         at_last;

    always_comb begin
        at_last = (cnt == LAST);
        wrap    = en & at_last & ~clr;
        if (clr)
            nxt = LAST;
        else if (en)
            nxt = at_last ? '0 : cnt + 1'b1;
        else
            nxt = cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= LAST;
        else
            cnt <= nxt;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator, advanced by the pixel strobe as a clock enable.
// Outputs are registered from the next-state counter values so they move with the counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic              en,
    vga_timing_gen_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    logic             tick;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_d;
    logic             vs_d;
    logic             vo_d;

    assign tick = en & pix_ce;

    // Dropping en parks both counters at their last value so the first tick wraps to (0,0).
    mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .clr   (~en),
        .nxt   (h_nxt),
        .wrap  (h_wrap)
    );

    mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick & h_wrap),
        .clr   (~en),
        .nxt   (v_nxt),
        .wrap  (v_wrap)
    );

    always_comb begin
        vo_d = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        hs_d = ((int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d = ((int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.x           <= '0;
            vid.y           <= '0;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.video_on    <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (!en) begin
            vid.x           <= '0;
            vid.y           <= '0;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.video_on    <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (pix_ce) begin
            vid.x           <= h_nxt;
            vid.y           <= v_nxt;
            vid.hsync       <= hs_d;
            vid.vsync       <= vs_d;
            vid.video_on    <= vo_d;
            vid.line_start  <= h_wrap;
            vid.frame_start <= v_wrap;
        end else begin
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a shrunken active-high-sync
// instance (16x12) so whole frames fit in a short run. Both share one stimulus stream.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic [9:0] x;
        logic [9:0] y;
        logic       line_start;
        logic       frame_start;
    } out_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit pol;
    } tim_t;

    typedef struct packed {
        bit   r;
        bit   e;
        bit   p;
        out_t exp;
    } vec_t;

    localparam int SMALL_FRAME = 16 * 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_ce = 1'b0;
    logic en = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vga_timing_gen_if #(.CNT_W(10)) vid0 ();
    vga_timing_gen_if #(.CNT_W(5))  vid1 ();

    vga_timing_gen dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce),
        .en     (en),
        .vid    (vid0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .CNT_W(5)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce),
        .en     (en),
        .vid    (vid1)
    );

    always #5 clk = ~clk;

    tim_t tm[2];
    int   mh[2];
    int   mv[2];
    out_t mo[2];
    out_t exp_q0[$];
    out_t exp_q1[$];

    int tk = 0;
    int last_fs = 0;
    bit have_fs = 1'b0;
    int intervals = 0;

    function automatic out_t rst_out(input bit pol);
        out_t o;
        o = '0;
        o.hsync = ~pol;
        o.vsync = ~pol;
        return o;
    endfunction

    function automatic void model(input int d, input bit r, input bit e, input bit p);
        int ht, vt, hsb, vsb;
        bit hw, fw;
        ht  = tm[d].ha + tm[d].hf + tm[d].hs + tm[d].hb;
        vt  = tm[d].va + tm[d].vf + tm[d].vs + tm[d].vb;
        hsb = tm[d].ha + tm[d].hf;
        vsb = tm[d].va + tm[d].vf;
        if (!r || !e) begin
            mh[d] = ht - 1;
            mv[d] = vt - 1;
            mo[d] = rst_out(tm[d].pol);
        end else if (p) begin
            hw = (mh[d] == ht - 1);
            fw = 1'b0;
            mh[d] = hw ? 0 : mh[d] + 1;
            if (hw) begin
                fw = (mv[d] == vt - 1);
                mv[d] = fw ? 0 : mv[d] + 1;
            end
            mo[d].x           = 10'(mh[d]);
            mo[d].y           = 10'(mv[d]);
            mo[d].video_on    = (mh[d] < tm[d].ha) && (mv[d] < tm[d].va);
            mo[d].hsync       = (mh[d] >= hsb && mh[d] < hsb + tm[d].hs) ? tm[d].pol : ~tm[d].pol;
            mo[d].vsync       = (mv[d] >= vsb && mv[d] < vsb + tm[d].vs) ? tm[d].pol : ~tm[d].pol;
            mo[d].line_start  = hw;
            mo[d].frame_start = hw && fw;
        end else begin
            mo[d].line_start  = 1'b0;
            mo[d].frame_start = 1'b0;
        end
    endfunction

    function automatic out_t act0();
        out_t o;
        o = '{hsync: vid0.hsync, vsync: vid0.vsync, video_on: vid0.video_on,
              x: vid0.x, y: vid0.y,
              line_start: vid0.line_start, frame_start: vid0.frame_start};
        return o;
    endfunction

    function automatic out_t act1();
        out_t o;
        o = '{hsync: vid1.hsync, vsync: vid1.vsync, video_on: vid1.video_on,
              x: 10'(vid1.x), y: 10'(vid1.y),
              line_start: vid1.line_start, frame_start: vid1.frame_start};
        return o;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    task automatic cmp_out(input string nm, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got hs=%0b vs=%0b vo=%0b x=%0d y=%0d ls=%0b fs=%0b want hs=%0b vs=%0b vo=%0b x=%0d y=%0d ls=%0b fs=%0b",
                     nm, cyc, got.hsync, got.vsync, got.video_on, got.x, got.y, got.line_start, got.frame_start,
                     want.hsync, want.vsync, want.video_on, want.x, want.y, want.line_start, want.frame_start);
        end
    endtask

    // Drive one clock of stimulus, queue the model's expectation, then compare after the edge.
    task automatic step(input bit r, input bit e, input bit p);
        out_t w;
        @(negedge clk);
        rst_n  = r;
        en     = e;
        pix_ce = p;
        model(0, r, e, p);
        model(1, r, e, p);
        exp_q0.push_back(mo[0]);
        exp_q1.push_back(mo[1]);
        if (r && e && p) tk++;
        if (!r || !e) have_fs = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            $display("FAIL sb_empty cyc=%0d got=0 want=1", cyc);
            $fatal(1, "scoreboard underflow");
        end
        w = exp_q0.pop_front();
        cmp_out("sb_dut0", act0(), w);
        w = exp_q1.pop_front();
        cmp_out("sb_dut1", act1(), w);
        if (vid1.frame_start) begin
            if (have_fs) begin
                chk("frame_interval", tk - last_fs, SMALL_FRAME);
                intervals++;
            end
            last_fs = tk;
            have_fs = 1'b1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
    endtask

    task automatic first_tick_chk(input string tag);
        chk({tag, "_fs0"}, int'(vid0.frame_start), 1);
        chk({tag, "_ls0"}, int'(vid0.line_start), 1);
        chk({tag, "_x0"},  int'(vid0.x), 0);
        chk({tag, "_y0"},  int'(vid0.y), 0);
        chk({tag, "_vo0"}, int'(vid0.video_on), 1);
        chk({tag, "_fs1"}, int'(vid1.frame_start), 1);
        chk({tag, "_vo1"}, int'(vid1.video_on), 1);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_x"},  int'(vid0.x), 0);
        chk({tag, "_hs"}, int'(vid0.hsync), 1);
        chk({tag, "_vo"}, int'(vid0.video_on), 0);
        chk({tag, "_hs1"}, int'(vid1.hsync), 0);
    endtask

    vec_t tbl[8];

    initial begin
        tm[0] = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
        tm[1] = '{ha: 8,   hf: 2,  hs: 3,  hb: 3,  va: 6,   vf: 2,  vs: 2, vb: 2,  pol: 1'b1};
        for (int d = 0; d < 2; d++) model(d, 1'b0, 1'b0, 1'b0);

        // {rst_n, en, pix_ce} and hand-derived dut0 outputs for the opening sequence.
        tbl[0] = '{r:0, e:1, p:0, exp:'{hsync:1, vsync:1, video_on:0, x:0, y:0, line_start:0, frame_start:0}};
        tbl[1] = '{r:1, e:1, p:0, exp:'{hsync:1, vsync:1, video_on:0, x:0, y:0, line_start:0, frame_start:0}};
        tbl[2] = '{r:1, e:1, p:0, exp:'{hsync:1, vsync:1, video_on:0, x:0, y:0, line_start:0, frame_start:0}};
        tbl[3] = '{r:1, e:1, p:1, exp:'{hsync:1, vsync:1, video_on:1, x:0, y:0, line_start:1, frame_start:1}};
        tbl[4] = '{r:1, e:1, p:0, exp:'{hsync:1, vsync:1, video_on:1, x:0, y:0, line_start:0, frame_start:0}};
        tbl[5] = '{r:1, e:1, p:1, exp:'{hsync:1, vsync:1, video_on:1, x:1, y:0, line_start:0, frame_start:0}};
        tbl[6] = '{r:1, e:0, p:1, exp:'{hsync:1, vsync:1, video_on:0, x:0, y:0, line_start:0, frame_start:0}};
        tbl[7] = '{r:1, e:1, p:1, exp:'{hsync:1, vsync:1, video_on:1, x:0, y:0, line_start:1, frame_start:1}};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].p);
            cmp_out($sformatf("vec%0d", i), act0(), tbl[i].exp);
        end

        // Horizontal boundaries on the default instance, starting at x=0.
        ticks(639);
        chk("vo_x639", int'(vid0.video_on), 1);
        ticks(1);
        chk("vo_x640", int'(vid0.video_on), 0);
        ticks(15);
        chk("hs_x655", int'(vid0.hsync), 1);
        ticks(1);
        chk("hs_x656", int'(vid0.hsync), 0);
        ticks(95);
        chk("hs_x751", int'(vid0.hsync), 0);
        ticks(1);
        chk("hs_x752", int'(vid0.hsync), 1);
        ticks(47);
        chk("x799", int'(vid0.x), 799);
        ticks(1);
        chk("wrap_x", int'(vid0.x), 0);
        chk("wrap_y", int'(vid0.y), 1);
        chk("wrap_ls", int'(vid0.line_start), 1);
        chk("wrap_fs", int'(vid0.frame_start), 0);

        // en dropped mid-line.
        ticks(300);
        chk("pre_en_x", int'(vid0.x), 300);
        step(1'b1, 1'b0, 1'b1);
        idle_chk("en_low");
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle_chk("en_idle");
        step(1'b1, 1'b1, 1'b1);
        first_tick_chk("en_first");

        // Asynchronous reset mid-line: outputs must clear before any clock edge.
        ticks(300);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        idle_chk("async_rst");
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        idle_chk("rst_idle");
        step(1'b1, 1'b1, 1'b1);
        first_tick_chk("rst_first");

        // Pixel strobe every 4th clock across more than two small frames.
        for (int i = 0; i < 2 * SMALL_FRAME + 20; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1);
        end
        chk("interval_seen", (intervals >= 2) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
